// File: rtl/memory_unit_if.sv
// Bus between the control path (MAR/MBR side) and the memory unit.
//
// Handshake: a request is a single-cycle strobe (C_rd or C_wr) that the
// memory samples only while idle; address and write data are captured on
// that same edge. Completion is signalled by a one-cycle mem_ready pulse,
// with read data valid on memory_out_MBR in that cycle. Strobes seen while
// mem_busy is high are dropped. Both strobes together is a protocol error.
interface memory_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] MAR_out_memory;
  logic [DATA_W-1:0] MBR_out_memory;
  logic              C_rd;
  logic              C_wr;
  logic [DATA_W-1:0] memory_out_MBR;
  logic              mem_ready;
  logic              mem_busy;
  logic              mem_err;

  modport master (
    output MAR_out_memory, MBR_out_memory, C_rd, C_wr,
    input  memory_out_MBR, mem_ready, mem_busy, mem_err
  );

  modport slave (
    input  MAR_out_memory, MBR_out_memory, C_rd, C_wr,
    output memory_out_MBR, mem_ready, mem_busy, mem_err
  );
endinterface

// File: rtl/memory_unit.sv
// Word-addressed memory with a fixed number of wait states per access.
// One access at a time; request inputs are latched on the accepting edge.
module memory_unit #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  memory_unit_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem_array [0:DEPTH-1];

  // Next-state logic: accept a request in IDLE, count wait states, then
  // complete the access and pulse ready for exactly one cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.C_rd && bus.C_wr) begin
          err_d = 1'b1;
        end else if (bus.C_rd) begin
          addr_d  = bus.MAR_out_memory;
          cnt_d   = 4'(WAIT_STATES);
          state_d = RD_WAIT;
        end else if (bus.C_wr) begin
          addr_d  = bus.MAR_out_memory;
          wdata_d = bus.MBR_out_memory;
          cnt_d   = 4'(WAIT_STATES);
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = mem_array[addr_q];
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array, deliberately not reset; writes only at completion.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[addr_q] <= wdata_q;
    end
  end

  assign bus.memory_out_MBR = rdata_q;
  assign bus.mem_ready      = ready_q;
  assign bus.mem_busy       = (state_q != IDLE);
  assign bus.mem_err        = err_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: two instances (one and zero wait states) driven
// in turn, checked against a flat array model of memory contents.
module tb_memory_unit;
  localparam int AW = 8;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_unit_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
  memory_unit_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();
  logic [1:0] dbg_a, dbg_b;

  memory_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .dbg_state(dbg_a)
  );
  memory_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .dbg_state(dbg_b)
  );

  // unit 0 = dut_a, unit 1 = dut_b
  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          o_rdy [2];
  logic          o_busy [2];
  logic          o_err [2];
  logic [DW-1:0] o_rdata [2];
  logic [1:0]    o_state [2];

  assign if_a.C_rd = rd[0];
  assign if_a.C_wr = wr[0];
  assign if_a.MAR_out_memory = addr[0];
  assign if_a.MBR_out_memory = wdata[0];
  assign if_b.C_rd = rd[1];
  assign if_b.C_wr = wr[1];
  assign if_b.MAR_out_memory = addr[1];
  assign if_b.MBR_out_memory = wdata[1];

  assign o_rdy[0] = if_a.mem_ready;
  assign o_busy[0] = if_a.mem_busy;
  assign o_err[0] = if_a.mem_err;
  assign o_rdata[0] = if_a.memory_out_MBR;
  assign o_state[0] = dbg_a;
  assign o_rdy[1] = if_b.mem_ready;
  assign o_busy[1] = if_b.mem_busy;
  assign o_err[1] = if_b.mem_err;
  assign o_rdata[1] = if_b.memory_out_MBR;
  assign o_state[1] = dbg_b;

  // ---------------- reference model ----------------
  int            ws [2] = '{1, 0};
  logic [DW-1:0] m_mem [2][256];
  bit            m_valid [2][256];
  logic [DW-1:0] m_rdata [2];
  bit            m_rknown [2];
  bit            m_err [2];
  logic [DW-1:0] exp_q [$];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk({tag, "_rdata"}, o_rdata[u], 0);
      chk({tag, "_ready"}, o_rdy[u], 0);
      chk({tag, "_busy"}, o_busy[u], 0);
      chk({tag, "_err"}, o_err[u], 0);
      chk({tag, "_state"}, o_state[u], 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after an edge. Issues one request, then moves the request
  // inputs to a different address/data so late changes would be visible.
  // poke re-asserts strobes during the wait cycles, which must be ignored.
  task automatic access(input int u, input bit is_wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit poke);
    bit known;
    logic [DW-1:0] e;
    known = 1'b0;
    addr[u] = a; wdata[u] = d; rd[u] = !is_wr; wr[u] = is_wr;
    if (!is_wr) begin
      known = m_valid[u][a];
      exp_q.push_back(m_mem[u][a]);
    end
    @(posedge clk); #1;
    rd[u] = 1'b0; wr[u] = 1'b0;
    addr[u] = a + 8'd1; wdata[u] = ~d;
    chk("req_busy", o_busy[u], 1);
    chk("req_ready", o_rdy[u], 0);
    for (int i = 0; i < ws[u]; i++) begin
      if (poke && i == 0) begin
        rd[u] = 1'b1;
        wr[u] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      rd[u] = 1'b0; wr[u] = 1'b0;
      chk("wait_busy", o_busy[u], 1);
      chk("wait_ready", o_rdy[u], 0);
    end
    @(posedge clk); #1;
    chk("done_ready", o_rdy[u], 1);
    chk("done_busy", o_busy[u], 0);
    if (is_wr) begin
      m_mem[u][a] = d;
      m_valid[u][a] = 1'b1;
    end else begin
      e = exp_q.pop_front();
      m_rdata[u] = e;
      m_rknown[u] = known;
    end
    if (m_rknown[u]) chk(is_wr ? "rdata_hold" : "rdata", o_rdata[u], m_rdata[u]);
    chk("err_flag", o_err[u], m_err[u]);
  endtask

  task automatic idle_cycle(input int u);
    @(posedge clk); #1;
    chk("idle_ready", o_rdy[u], 0);
    chk("idle_busy", o_busy[u], 0);
  endtask

  task automatic both_strobes(input int u);
    addr[u] = 8'($urandom); rd[u] = 1'b1; wr[u] = 1'b1;
    @(posedge clk); #1;
    rd[u] = 1'b0; wr[u] = 1'b0;
    m_err[u] = 1'b1;
    chk("both_busy", o_busy[u], 0);
    chk("both_ready", o_rdy[u], 0);
    chk("both_err", o_err[u], 1);
    chk("both_state", o_state[u], 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
      m_rdata[u] = '0; m_rknown[u] = 1'b1; m_err[u] = 1'b0;
      for (int j = 0; j < 256; j++) m_valid[u][j] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // write then read back, one wait state
    access(0, 1'b1, 8'h10, 16'hBEEF, 1'b0);
    access(0, 1'b0, 8'h10, 16'h0000, 1'b0);

    // zero wait states, back-to-back at minimum period, both ends of range
    access(1, 1'b1, 8'h00, 16'h1234, 1'b0);
    access(1, 1'b1, 8'hFF, 16'hABCD, 1'b0);
    access(1, 1'b0, 8'h00, 16'h0000, 1'b0);
    access(1, 1'b0, 8'hFF, 16'h0000, 1'b0);

    // inputs moved to 0x21 right after the request edge must not leak
    for (int u = 0; u < 2; u++) begin
      access(u, 1'b1, 8'h21, 16'h7777, 1'b0);
      access(u, 1'b1, 8'h20, 16'h1111, 1'b0);
      access(u, 1'b0, 8'h20, 16'h0000, 1'b0);
      access(u, 1'b0, 8'h21, 16'h0000, 1'b0);
    end

    // strobes during the wait cycle are ignored, no error
    access(0, 1'b0, 8'h10, 16'h0000, 1'b1);
    access(0, 1'b1, 8'h30, 16'h3C3C, 1'b1);
    idle_cycle(0);

    // protocol error is sticky across good accesses
    both_strobes(0);
    idle_cycle(0);
    access(0, 1'b1, 8'h31, 16'h0F0F, 1'b0);
    access(0, 1'b0, 8'h31, 16'h0000, 1'b0);
    both_strobes(1);
    access(1, 1'b0, 8'h00, 16'h0000, 1'b0);

    // randomized traffic on a small address window plus the top page
    for (int n = 0; n < 80; n++) begin
      int u;
      bit w;
      logic [AW-1:0] a;
      u = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(240, 255));
      access(u, w, a, 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle(u);
    end

    // reset during a pending write: write is dropped, error cleared
    access(0, 1'b1, 8'h40, 16'h5555, 1'b0);
    addr[0] = 8'h40; wdata[0] = 16'hAAAA; wr[0] = 1'b1;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    chk("pre_reset_busy", o_busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(posedge clk); #1;
    chk_reset_vals("held_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      m_err[u] = 1'b0; m_rdata[u] = '0; m_rknown[u] = 1'b1;
    end
    @(posedge clk); #1;
    access(0, 1'b1, 8'h41, 16'h9999, 1'b0);
    access(0, 1'b0, 8'h40, 16'h0000, 1'b0);
    access(1, 1'b0, 8'hFF, 16'h0000, 1'b0);
    idle_cycle(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
